otter_id_ex_stage: RTL and testbench

ID/EX pipeline stage directly upstream of the OTTER ALU.
- Registers decoded operands from ID.
- Resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards and inserts bubbles.
- Drives the ALU A, B and alu_fun inputs (4-bit encoding: 0000 add, 1000 sub, 1001 copy, etc.).
- Forwards store data and destination info downstream.

---
 rtl/otter_pkg.sv | 35 +++
 rtl/otter_fwd_unit.sv | 32 +++
 rtl/otter_id_ex_stage.sv | 136 +++++++++++++
 tb/tb_otter_id_ex_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared constants and encodings for the OTTER ID/EX stage.
//   XLEN, RADDR_W : datapath and register-address widths
//   alu_fun_t     : ALU operation encodings as seen by the OTTER ALU
//   a_sel_t       : ALU A source select
//   b_sel_t       : ALU B source select
package otter_pkg;
   localparam int XLEN    = 32;
   localparam int RADDR_W = 5;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111,
      ALU_SUB  = 4'b1000,
      ALU_COPY = 4'b1001,
      ALU_SRA  = 4'b1101
   } alu_fun_t;

   typedef enum logic {
      A_RS1 = 1'b0,
      A_PC  = 1'b1
   } a_sel_t;

   typedef enum logic [1:0] {
      B_RS2     = 2'b00,
      B_IMM     = 2'b01,
      B_FOUR    = 2'b10,
      B_RS2_ALT = 2'b11
   } b_sel_t;
endpackage

// File: rtl/otter_fwd_unit.sv
// Combinational operand forwarding for one source register.
//   src_addr    : registered source register address
//   reg_data    : registered register-file read data
//   mem_*       : MEM-stage destination, write enable, result
//   wb_*        : WB-stage destination, write enable, write data
//   data        : forwarded operand (MEM beats WB; x0 never forwards)
module otter_fwd_unit
   import otter_pkg::*;
#(
   parameter int XLEN    = otter_pkg::XLEN,
   parameter int RADDR_W = otter_pkg::RADDR_W
) (
   input  logic [RADDR_W-1:0] src_addr,
   input  logic [XLEN-1:0]    reg_data,
   input  logic               mem_reg_wr,
   input  logic [RADDR_W-1:0] mem_rd_addr,
   input  logic [XLEN-1:0]    mem_result,
   input  logic               wb_reg_wr,
   input  logic [RADDR_W-1:0] wb_rd_addr,
   input  logic [XLEN-1:0]    wb_data,
   output logic [XLEN-1:0]    data
);
   always_comb begin
      data = reg_data;
      if (src_addr != '0) begin
         if (mem_reg_wr && (mem_rd_addr == src_addr))
            data = mem_result;
         else if (wb_reg_wr && (wb_rd_addr == src_addr))
            data = wb_data;
      end
   end
endmodule

// File: rtl/otter_id_ex_stage.sv
// ID/EX pipeline register feeding the OTTER ALU.
//   CLK, RST       : clock, synchronous active-high reset
//   id_*           : decoded instruction fields from ID
//   flush, hold    : kill the entering instruction / freeze EX
//   mem_*, wb_*    : downstream destinations for forwarding
//   alu_a/b/fun    : ALU operands and op
//   ex_*           : registered instruction info for downstream stages
//   stall_id       : upstream must hold PC and IF/ID
module otter_id_ex_stage
   import otter_pkg::*;
#(
   parameter int XLEN    = otter_pkg::XLEN,
   parameter int RADDR_W = otter_pkg::RADDR_W
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               id_valid,
   input  logic [XLEN-1:0]    id_pc,
   input  logic [RADDR_W-1:0] id_rs1_addr,
   input  logic [RADDR_W-1:0] id_rs2_addr,
   input  logic [XLEN-1:0]    id_rs1_data,
   input  logic [XLEN-1:0]    id_rs2_data,
   input  logic               id_uses_rs1,
   input  logic               id_uses_rs2,
   input  logic [XLEN-1:0]    id_imm,
   input  logic               id_a_sel,
   input  logic [1:0]         id_b_sel,
   input  logic [3:0]         id_alu_fun,
   input  logic [RADDR_W-1:0] id_rd_addr,
   input  logic               id_reg_wr,
   input  logic               id_mem_rd,
   input  logic               id_mem_wr,
   input  logic               flush,
   input  logic               hold,
   input  logic [RADDR_W-1:0] mem_rd_addr,
   input  logic               mem_reg_wr,
   input  logic [XLEN-1:0]    mem_result,
   input  logic [RADDR_W-1:0] wb_rd_addr,
   input  logic               wb_reg_wr,
   input  logic [XLEN-1:0]    wb_data,
   output logic [XLEN-1:0]    alu_a,
   output logic [XLEN-1:0]    alu_b,
   output logic [3:0]         alu_fun,
   output logic               ex_valid,
   output logic [XLEN-1:0]    ex_pc,
   output logic [RADDR_W-1:0] ex_rd_addr,
   output logic               ex_reg_wr,
   output logic               ex_mem_rd,
   output logic               ex_mem_wr,
   output logic [XLEN-1:0]    ex_store_data,
   output logic               stall_id
);
   logic               valid_q;
   logic [XLEN-1:0]    pc_q, rs1_data_q, rs2_data_q, imm_q;
   logic [RADDR_W-1:0] rs1_addr_q, rs2_addr_q, rd_addr_q;
   a_sel_t             a_sel_q;
   b_sel_t             b_sel_q;
   alu_fun_t           fun_q;
   logic               reg_wr_q, mem_rd_q, mem_wr_q;
   logic [XLEN-1:0]    fwd_rs1, fwd_rs2;
   logic               load_use;

   // A load in EX cannot forward its data in time for a dependent ID op.
   assign load_use = valid_q && mem_rd_q && (rd_addr_q != '0) && id_valid &&
                     ((id_uses_rs1 && (id_rs1_addr == rd_addr_q)) ||
                      (id_uses_rs2 && (id_rs2_addr == rd_addr_q)));

   // hold outranks flush; flush makes a load-use stall pointless.
   assign stall_id = !RST && (hold || (!flush && load_use));

   always_ff @(posedge CLK) begin
      if (RST || (!hold && (flush || load_use))) begin
         valid_q    <= 1'b0;
         pc_q       <= '0;
         rs1_addr_q <= '0;
         rs2_addr_q <= '0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
         imm_q      <= '0;
         a_sel_q    <= A_RS1;
         b_sel_q    <= B_RS2;
         fun_q      <= ALU_ADD;
         rd_addr_q  <= '0;
         reg_wr_q   <= 1'b0;
         mem_rd_q   <= 1'b0;
         mem_wr_q   <= 1'b0;
      end else if (!hold) begin
         valid_q    <= id_valid;
         pc_q       <= id_pc;
         rs1_addr_q <= id_rs1_addr;
         rs2_addr_q <= id_rs2_addr;
         rs1_data_q <= id_rs1_data;
         rs2_data_q <= id_rs2_data;
         imm_q      <= id_imm;
         a_sel_q    <= a_sel_t'(id_a_sel);
         b_sel_q    <= b_sel_t'(id_b_sel);
         fun_q      <= alu_fun_t'(id_alu_fun);
         rd_addr_q  <= id_rd_addr;
         reg_wr_q   <= id_reg_wr;
         mem_rd_q   <= id_mem_rd;
         mem_wr_q   <= id_mem_wr;
      end
   end

   otter_fwd_unit #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
      .src_addr(rs1_addr_q), .reg_data(rs1_data_q),
      .mem_reg_wr(mem_reg_wr), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
      .wb_reg_wr(wb_reg_wr), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
      .data(fwd_rs1)
   );

   otter_fwd_unit #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
      .src_addr(rs2_addr_q), .reg_data(rs2_data_q),
      .mem_reg_wr(mem_reg_wr), .mem_rd_addr(mem_rd_addr), .mem_result(mem_result),
      .wb_reg_wr(wb_reg_wr), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
      .data(fwd_rs2)
   );

   always_comb begin
      alu_a = (a_sel_q == A_PC) ? pc_q : fwd_rs1;
      case (b_sel_q)
         B_IMM:   alu_b = imm_q;
         B_FOUR:  alu_b = XLEN'(4);
         default: alu_b = fwd_rs2;
      endcase
   end

   assign alu_fun       = fun_q;
   assign ex_valid      = valid_q;
   assign ex_pc         = pc_q;
   assign ex_rd_addr    = rd_addr_q;
   assign ex_reg_wr     = valid_q && reg_wr_q;
   assign ex_mem_rd     = valid_q && mem_rd_q;
   assign ex_mem_wr     = valid_q && mem_wr_q;
   assign ex_store_data = fwd_rs2;
endmodule

// File: tb/tb_otter_id_ex_stage.sv
// Self-checking bench for otter_id_ex_stage: directed scenarios with literal
// expectations plus a randomized run against a behavioural EX-slot model.
module tb_otter_id_ex_stage;
   logic        CLK = 1'b0;
   logic        RST;
   logic        id_valid, id_uses_rs1, id_uses_rs2, id_a_sel;
   logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [1:0]  id_b_sel;
   logic [3:0]  id_alu_fun;
   logic        id_reg_wr, id_mem_rd, id_mem_wr, flush, hold;
   logic [4:0]  mem_rd_addr, wb_rd_addr;
   logic        mem_reg_wr, wb_reg_wr;
   logic [31:0] mem_result, wb_data;
   logic [31:0] alu_a, alu_b, ex_pc, ex_store_data;
   logic [3:0]  alu_fun;
   logic [4:0]  ex_rd_addr;
   logic        ex_valid, ex_reg_wr, ex_mem_rd, ex_mem_wr, stall_id;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   otter_id_ex_stage dut (
      .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_imm(id_imm),
      .id_a_sel(id_a_sel), .id_b_sel(id_b_sel), .id_alu_fun(id_alu_fun),
      .id_rd_addr(id_rd_addr), .id_reg_wr(id_reg_wr), .id_mem_rd(id_mem_rd),
      .id_mem_wr(id_mem_wr), .flush(flush), .hold(hold),
      .mem_rd_addr(mem_rd_addr), .mem_reg_wr(mem_reg_wr), .mem_result(mem_result),
      .wb_rd_addr(wb_rd_addr), .wb_reg_wr(wb_reg_wr), .wb_data(wb_data),
      .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .ex_valid(ex_valid),
      .ex_pc(ex_pc), .ex_rd_addr(ex_rd_addr), .ex_reg_wr(ex_reg_wr),
      .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
      .ex_store_data(ex_store_data), .stall_id(stall_id)
   );

   always #5 CLK = ~CLK;

   // Behavioural model: the instruction currently occupying EX.
   typedef struct packed {
      logic        v;
      logic [31:0] pc, rs1d, rs2d, imm;
      logic [4:0]  rs1a, rs2a, rd;
      logic        asel;
      logic [1:0]  bsel;
      logic [3:0]  fun;
      logic        regwr, memrd, memwr;
   } ex_t;
   ex_t m;

   function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
      if (a == 5'd0) return rf;
      if (mem_reg_wr && mem_rd_addr == a) return mem_result;
      if (wb_reg_wr && wb_rd_addr == a) return wb_data;
      return rf;
   endfunction

   function automatic logic dep_on_load();
      return m.v && m.memrd && m.rd != 5'd0 && id_valid &&
             ((id_uses_rs1 && id_rs1_addr == m.rd) || (id_uses_rs2 && id_rs2_addr == m.rd));
   endfunction

   always @(posedge CLK) begin
      if (RST) m = '0;
      else if (hold) m = m;
      else if (flush || dep_on_load()) m = '0;
      else begin
         m.v = id_valid; m.pc = id_pc; m.rs1d = id_rs1_data; m.rs2d = id_rs2_data;
         m.imm = id_imm; m.rs1a = id_rs1_addr; m.rs2a = id_rs2_addr; m.rd = id_rd_addr;
         m.asel = id_a_sel; m.bsel = id_b_sel; m.fun = id_alu_fun;
         m.regwr = id_reg_wr; m.memrd = id_mem_rd; m.memwr = id_mem_wr;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model.
   always @(negedge CLK) begin
      if (chk_en) begin
         logic [31:0] ea, eb, es;
         logic        est;
         ea  = m.asel ? m.pc : fwd(m.rs1a, m.rs1d);
         es  = fwd(m.rs2a, m.rs2d);
         eb  = (m.bsel == 2'b01) ? m.imm : (m.bsel == 2'b10) ? 32'd4 : es;
         est = RST ? 1'b0 : hold ? 1'b1 : flush ? 1'b0 : dep_on_load();
         chk("m_alu_a", alu_a, ea);
         chk("m_alu_b", alu_b, eb);
         chk("m_alu_fun", {28'd0, alu_fun}, {28'd0, m.fun});
         chk("m_ex_valid", {31'd0, ex_valid}, {31'd0, m.v});
         chk("m_ex_pc", ex_pc, m.pc);
         chk("m_ex_rd", {27'd0, ex_rd_addr}, {27'd0, m.rd});
         chk("m_ctrl", {29'd0, ex_reg_wr, ex_mem_rd, ex_mem_wr},
             {29'd0, m.v & m.regwr, m.v & m.memrd, m.v & m.memwr});
         chk("m_store", ex_store_data, es);
         chk("m_stall", {31'd0, stall_id}, {31'd0, est});
      end
   end

   task automatic id_idle();
      id_valid = 0; id_pc = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_data = 0;
      id_rs2_data = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_imm = 0; id_a_sel = 0;
      id_b_sel = 0; id_alu_fun = 0; id_rd_addr = 0; id_reg_wr = 0; id_mem_rd = 0;
      id_mem_wr = 0; flush = 0; hold = 0;
   endtask

   task automatic fw_idle();
      mem_rd_addr = 0; mem_reg_wr = 0; mem_result = 0;
      wb_rd_addr = 0; wb_reg_wr = 0; wb_data = 0;
   endtask

   task automatic rand_id();
      id_valid = 1'($urandom_range(0, 3) != 0);
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1_addr = 5'($urandom_range(0, 7)); id_rs2_addr = 5'($urandom_range(0, 7));
      id_rd_addr = 5'($urandom_range(0, 7));
      id_uses_rs1 = 1'($urandom); id_uses_rs2 = 1'($urandom); id_a_sel = 1'($urandom);
      id_b_sel = 2'($urandom); id_alu_fun = 4'($urandom);
      id_reg_wr = 1'($urandom); id_mem_rd = 1'($urandom_range(0, 2) == 0);
      id_mem_wr = 1'($urandom);
   endtask

   task automatic rand_fw();
      mem_rd_addr = 5'($urandom_range(0, 7)); mem_reg_wr = 1'($urandom); mem_result = $urandom;
      wb_rd_addr = 5'($urandom_range(0, 7)); wb_reg_wr = 1'($urandom); wb_data = $urandom;
   endtask

   task automatic tick();
      @(posedge CLK); #1;
   endtask

   task automatic load_lw7();
      id_idle(); id_valid = 1; id_rd_addr = 7; id_reg_wr = 1; id_mem_rd = 1;
      id_rs1_addr = 2; id_uses_rs1 = 1;
   endtask

   initial begin
      // Reset with random inputs for two cycles.
      RST = 1; rand_id(); rand_fw(); hold = 1'($urandom); flush = 1'($urandom);
      @(posedge CLK); chk_en = 1; #1;
      rand_id(); rand_fw(); hold = 1; flush = 0;
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("rst_valid", {31'd0, ex_valid}, 32'd0);
      chk("rst_fun", {28'd0, alu_fun}, 32'd0);
      chk("rst_stall", {31'd0, stall_id}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      @(posedge CLK); #1;
      RST = 0; id_idle(); fw_idle();

      // Forwarding priority.
      id_valid = 1; id_rs1_addr = 5; id_rs1_data = 32'h11; id_uses_rs1 = 1;
      tick();
      id_idle();
      mem_reg_wr = 1; mem_rd_addr = 5; mem_result = 32'h22;
      wb_reg_wr = 1; wb_rd_addr = 5; wb_data = 32'h33;
      @(negedge CLK); chk("fwd_mem", alu_a, 32'h22);
      #1 mem_reg_wr = 0;
      #1 chk("fwd_wb", alu_a, 32'h33);
      id_valid = 1; id_rs1_addr = 0; id_rs1_data = 32'h44; id_uses_rs1 = 1;
      mem_reg_wr = 1; mem_rd_addr = 0; wb_rd_addr = 0;
      tick();
      @(negedge CLK); chk("fwd_x0", alu_a, 32'h44);
      #1 fw_idle();

      // Load-use stall then bubble.
      load_lw7();
      tick();
      id_idle(); id_valid = 1; id_rs1_addr = 7; id_uses_rs1 = 1; id_rs2_addr = 3;
      id_uses_rs2 = 1; id_rd_addr = 8; id_reg_wr = 1;
      @(negedge CLK); chk("lu_stall", {31'd0, stall_id}, 32'd1);
      tick();
      @(negedge CLK);
      chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
      chk("lu_release", {31'd0, stall_id}, 32'd0);
      tick();
      @(negedge CLK);
      chk("lu_enter", {31'd0, ex_valid}, 32'd1);
      chk("lu_enter_rd", {27'd0, ex_rd_addr}, 32'd8);
      #1 load_lw7();
      tick();
      id_idle(); id_valid = 1; id_rs1_addr = 3; id_uses_rs1 = 1; id_rs2_addr = 7;
      id_uses_rs2 = 0;
      @(negedge CLK); chk("lu_unused_rs2", {31'd0, stall_id}, 32'd0);
      tick();
      @(negedge CLK); chk("lu_unused_enter", {31'd0, ex_valid}, 32'd1);

      // Operand select.
      #1 id_idle(); id_valid = 1; id_a_sel = 1; id_b_sel = 2'b10; id_pc = 32'h100;
      tick();
      @(negedge CLK);
      chk("sel_pc", alu_a, 32'h100);
      chk("sel_four", alu_b, 32'd4);
      chk("sel_fun", {28'd0, alu_fun}, 32'd0);
      #1 id_b_sel = 2'b01; id_imm = 32'hFFFF_FFF0;
      tick();
      @(negedge CLK); chk("sel_imm", alu_b, 32'hFFFF_FFF0);

      // Flush beats load-use.
      #1 load_lw7();
      tick();
      id_idle(); id_valid = 1; id_rs1_addr = 7; id_uses_rs1 = 1; flush = 1;
      @(negedge CLK); chk("fl_lu_stall", {31'd0, stall_id}, 32'd0);
      tick();
      @(negedge CLK); chk("fl_lu_bubble", {31'd0, ex_valid}, 32'd0);

      // Hold freezes EX; flush during hold waits for hold to drop.
      #1 id_idle(); id_valid = 1; id_pc = 32'h200; id_alu_fun = 4'b1000;
      id_rd_addr = 9; id_reg_wr = 1;
      tick();
      @(negedge CLK); chk("hold_pre_pc", ex_pc, 32'h200);
      for (int i = 0; i < 3; i++) begin
         #1 rand_id(); hold = 1; flush = (i == 2);
         @(posedge CLK);
         @(negedge CLK);
         chk("hold_pc", ex_pc, 32'h200);
         chk("hold_fun", {28'd0, alu_fun}, 32'd8);
         chk("hold_valid", {31'd0, ex_valid}, 32'd1);
         chk("hold_stall", {31'd0, stall_id}, 32'd1);
      end
      #1 hold = 0; flush = 1; rand_id(); id_valid = 1;
      @(posedge CLK);
      @(negedge CLK);
      chk("hold_flush_bubble", {31'd0, ex_valid}, 32'd0);
      chk("hold_flush_stall", {31'd0, stall_id}, 32'd0);
      #1 flush = 0;

      // Randomized run.
      for (int c = 0; c < 3000; c++) begin
         @(posedge CLK); #1;
         rand_id(); rand_fw();
         hold  = 1'($urandom_range(0, 9) == 0);
         flush = 1'($urandom_range(0, 7) == 0);
         RST   = 1'($urandom_range(0, 299) == 0);
      end
      @(posedge CLK); #1;
      @(negedge CLK); #1;
      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
